// File: rtl/updown_counter_n_pkg.sv
// Shared constants and helpers for the up/down modulo counter and its prescaler.
package updown_counter_n_pkg;

   localparam int CNT_WRAP = 0;
   localparam int CNT_SAT  = 1;

   // Phase register width: clog2(prescale), never narrower than one bit.
   function automatic int unsigned prescale_width(input int unsigned prescale);
      int unsigned w;
      w = 0;
      while ((64'd1 << w) < 64'(prescale)) w++;
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/updown_counter_n_tick_prescaler.sv
// Enable-gated divide-by-PRESCALE tick generator; phase holds while en is low.
module tick_prescaler
   import updown_counter_n_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   generate
      if (PRESCALE == 1) begin : g_bypass
         logic unused_ok;
         assign unused_ok = &{1'b0, clk, rst_n, clr};
         assign tick      = en;
      end else begin : g_div
         localparam int unsigned   PW   = prescale_width(PRESCALE);
         localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

         logic [PW-1:0] phase_q, phase_d;

         always_comb begin
            phase_d = phase_q;
            if (clr) begin
               phase_d = '0;
            end else if (en) begin
               phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) phase_q <= '0;
            else        phase_q <= phase_d;
         end

         assign tick = en && (phase_q == LAST);
      end
   endgenerate

endmodule

// File: rtl/updown_counter_n.sv
// Prescaled up/down counter over 0..MODULUS-1 with wrap or saturate behaviour,
// parallel load, ripple-carry pulse and combinational terminal count.
module updown_counter_n
   import updown_counter_n_pkg::*;
#(
   parameter int unsigned     WIDTH    = 16,
   parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
   parameter int              SATURATE = CNT_WRAP,
   parameter int unsigned     PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] pdata,
   output logic [WIDTH-1:0] cnt,
   output logic             rc,
   output logic             tc,
   output logic             sat
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic             tick;
   logic             at_end;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             rc_q, rc_d;
   logic             sat_q, sat_d;

   tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .clr  (load),
      .tick (tick)
   );

   assign at_end = up ? (cnt_q == MAX) : (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      rc_d  = 1'b0;
      sat_d = sat_q;
      if (load) begin
         cnt_d = (64'(pdata) >= MODULUS) ? MAX : pdata;
         sat_d = 1'b0;
      end else if (tick) begin
         if (!at_end) begin
            cnt_d = up ? cnt_q + ONE : cnt_q - ONE;
            sat_d = 1'b0;
         end else if (SATURATE == CNT_SAT) begin
            // Only the first blocked step pulses rc; later ones keep sat high quietly.
            rc_d  = !sat_q;
            sat_d = 1'b1;
         end else begin
            cnt_d = up ? '0 : MAX;
            rc_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         rc_q  <= 1'b0;
         sat_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         rc_q  <= rc_d;
         sat_q <= sat_d;
      end
   end

   assign cnt = cnt_q;
   assign rc  = rc_q;
   assign sat = sat_q;
   assign tc  = at_end;

endmodule

// File: tb/tb_updown_counter_n.sv
// Scoreboard bench: three counter configurations checked against a behavioural model.
module tb_updown_counter_n;
   import updown_counter_n_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] rst_n_v, en_v, up_v, load_v, rc_v, tc_v, sat_v;
   logic [3:0] pd_a, pd_c, cnt_a, cnt_c;
   logic [7:0] pd_b, cnt_b;

   // A: mod-10 wrap, B: 8-bit saturate, C: mod-8 saturate with prescale 3
   updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(CNT_WRAP), .PRESCALE(1)) u_a (
      .clk(clk), .rst_n(rst_n_v[0]), .en(en_v[0]), .up(up_v[0]), .load(load_v[0]),
      .pdata(pd_a), .cnt(cnt_a), .rc(rc_v[0]), .tc(tc_v[0]), .sat(sat_v[0]));
   updown_counter_n #(.WIDTH(8), .MODULUS(256), .SATURATE(CNT_SAT), .PRESCALE(1)) u_b (
      .clk(clk), .rst_n(rst_n_v[1]), .en(en_v[1]), .up(up_v[1]), .load(load_v[1]),
      .pdata(pd_b), .cnt(cnt_b), .rc(rc_v[1]), .tc(tc_v[1]), .sat(sat_v[1]));
   updown_counter_n #(.WIDTH(4), .MODULUS(8), .SATURATE(CNT_SAT), .PRESCALE(3)) u_c (
      .clk(clk), .rst_n(rst_n_v[2]), .en(en_v[2]), .up(up_v[2]), .load(load_v[2]),
      .pdata(pd_c), .cnt(cnt_c), .rc(rc_v[2]), .tc(tc_v[2]), .sat(sat_v[2]));

   typedef struct {
      int id;
      int cnt;
      bit rc;
      bit sat;
      bit tc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   int MOD [3] = '{10, 256, 8};
   int PRE [3] = '{1, 1, 3};
   bit SATM[3] = '{1'b0, 1'b1, 1'b1};
   int PMSK[3] = '{15, 255, 15};
   int m_cnt[3] = '{0, 0, 0};
   bit m_sat[3] = '{1'b0, 1'b0, 1'b0};
   int m_ph [3] = '{0, 0, 0};

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic compare();
      exp_t x;
      int   oc;
      x  = sb.pop_front();
      oc = (x.id == 0) ? int'(cnt_a) : (x.id == 1) ? int'(cnt_b) : int'(cnt_c);
      check($sformatf("cnt%0d", x.id), oc, x.cnt);
      check($sformatf("rc%0d", x.id), int'(rc_v[x.id]), int'(x.rc));
      check($sformatf("sat%0d", x.id), int'(sat_v[x.id]), int'(x.sat));
      check($sformatf("tc%0d", x.id), int'(tc_v[x.id]), int'(x.tc));
   endtask

   // Drive one cycle into DUT id (others idle), predict, then compare after the edge.
   task automatic cycle(input int id, input bit r, input bit e, input bit u,
                        input bit l, input int pd);
      exp_t x;
      int   pdw;
      int   nxt;
      @(negedge clk);
      en_v    = '0;
      load_v  = '0;
      rst_n_v = '1;
      rst_n_v[id] = r;
      en_v[id]    = e;
      up_v[id]    = u;
      load_v[id]  = l;
      case (id)
         0:       pd_a = 4'(pd);
         1:       pd_b = 8'(pd);
         default: pd_c = 4'(pd);
      endcase
      pdw  = pd & PMSK[id];
      x.id = id;
      x.rc = 1'b0;
      if (!r) begin
         m_cnt[id] = 0;
         m_sat[id] = 1'b0;
         m_ph[id]  = 0;
      end else if (l) begin
         m_cnt[id] = (pdw >= MOD[id]) ? MOD[id] - 1 : pdw;
         m_sat[id] = 1'b0;
         m_ph[id]  = 0;
      end else if (e) begin
         if (m_ph[id] == PRE[id] - 1) begin
            m_ph[id] = 0;
            nxt = u ? m_cnt[id] + 1 : m_cnt[id] - 1;
            if (nxt < 0 || nxt >= MOD[id]) begin
               if (SATM[id]) begin
                  x.rc      = !m_sat[id];
                  m_sat[id] = 1'b1;
               end else begin
                  m_cnt[id] = (nxt + MOD[id]) % MOD[id];
                  x.rc      = 1'b1;
               end
            end else begin
               m_cnt[id] = nxt;
               m_sat[id] = 1'b0;
            end
         end else begin
            m_ph[id]++;
         end
      end
      x.cnt = m_cnt[id];
      x.sat = m_sat[id];
      x.tc  = u ? (m_cnt[id] == MOD[id] - 1) : (m_cnt[id] == 0);
      sb.push_back(x);
      @(posedge clk);
      #1;
      compare();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal;
   end

   initial begin
      rst_n_v = '0; en_v = '0; up_v = '1; load_v = '0;
      pd_a = '0; pd_b = '0; pd_c = '0;
      repeat (2) @(posedge clk);
      rst_n_v = '1;

      // A: count up through the wrap, then clamped load and count down
      cycle(0, 0, 1, 1, 1, 5);
      for (int i = 0; i < 10; i++) cycle(0, 1, 1, 1, 0, 0);
      check("a_wrap_cnt", int'(cnt_a), 0);
      check("a_wrap_rc", int'(rc_v[0]), 1);
      cycle(0, 1, 1, 1, 1, 12);
      check("a_clamp", int'(cnt_a), 9);
      for (int i = 0; i < 10; i++) cycle(0, 1, 1, 0, 0, 0);
      check("a_down_wrap", int'(cnt_a), 9);

      // B: saturate at top and bottom, release on opposite step
      cycle(1, 0, 0, 1, 0, 0);
      cycle(1, 1, 0, 1, 1, 254);
      for (int i = 0; i < 3; i++) cycle(1, 1, 1, 1, 0, 0);
      cycle(1, 1, 1, 0, 0, 0);
      check("b_release", int'(cnt_b), 254);
      cycle(1, 1, 0, 0, 1, 0);
      cycle(1, 1, 1, 0, 0, 0);
      cycle(1, 1, 1, 0, 0, 0);
      cycle(1, 1, 1, 1, 0, 0);

      // C: prescale 3, en gaps, load vs due step, reset mid-phase/mid-saturation
      cycle(2, 0, 0, 1, 0, 0);
      for (int i = 0; i < 9; i++) cycle(2, 1, 1, 1, 0, 0);
      check("c_presc", int'(cnt_c), 3);
      cycle(2, 1, 1, 1, 0, 0);
      cycle(2, 1, 0, 1, 0, 0);
      cycle(2, 1, 0, 1, 0, 0);
      cycle(2, 1, 1, 1, 0, 0);
      cycle(2, 1, 1, 1, 0, 0);
      check("c_delayed", int'(cnt_c), 4);
      cycle(2, 1, 1, 1, 0, 0);
      cycle(2, 1, 1, 1, 0, 0);
      cycle(2, 1, 1, 1, 1, 5);
      for (int i = 0; i < 3; i++) cycle(2, 1, 1, 1, 0, 0);
      cycle(2, 1, 0, 1, 1, 7);
      for (int i = 0; i < 5; i++) cycle(2, 1, 1, 1, 0, 0);
      cycle(2, 0, 1, 1, 1, 3);
      for (int i = 0; i < 3; i++) cycle(2, 1, 1, 1, 0, 0);
      check("c_post_rst", int'(cnt_c), 1);

      // Mixed random traffic on all three configurations
      for (int i = 0; i < 200; i++) begin
         cycle($urandom_range(0, 2), $urandom_range(0, 24) != 0, $urandom_range(0, 3) != 0,
               1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, $urandom_range(0, 255));
      end

      check("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
